// File: rtl/output_collector.sv
// Collects per-channel output words into one-deep holding buffers and drains
// them round-robin onto a single valid/ready write interface.
module output_collector #(
    parameter int W_CHAN = 16,
    parameter int W_SEL  = 4,
    parameter int N_CHAN = 8
) (
    input  logic                       clk_in,
    input  logic                       rst_n_in,
    input  logic [W_CHAN*N_CHAN-1:0]   data_packed_in,
    input  logic [N_CHAN-1:0]          data_valid_in,
    input  logic [N_CHAN-1:0]          output_active_in,
    input  logic                       clear_overrun_in,
    output logic [W_CHAN-1:0]          data_out,
    output logic [W_SEL-1:0]           chan_out,
    output logic                       data_valid_out,
    input  logic                       data_ready_in,
    output logic [N_CHAN-1:0]          overrun_out
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;

    logic [0:0]        r_state;
    logic [N_CHAN-1:0] r_pending;
    logic [N_CHAN-1:0] r_overrun;
    logic [W_CHAN-1:0] r_hold [N_CHAN];
    logic [W_SEL-1:0]  r_ptr;
    logic [W_SEL-1:0]  r_chan;
    logic [W_CHAN-1:0] r_data;
    logic              r_valid;

    logic              w_lo_found;
    logic              w_hi_found;
    logic [W_SEL-1:0]  w_lo_idx;
    logic [W_SEL-1:0]  w_hi_idx;
    logic              w_grant_found;
    logic [W_SEL-1:0]  w_grant_idx;
    logic [W_CHAN-1:0] w_grant_data;
    logic              w_fire;
    logic [W_SEL-1:0]  w_ptr_nxt;
    logic [N_CHAN-1:0] w_capture;
    logic [N_CHAN-1:0] w_granted;
    logic [N_CHAN-1:0] w_overrun_set;
    logic [N_CHAN-1:0] w_pending_nxt;

    // Round-robin search: lowest pending index at or above ptr, else lowest overall (wrap).
    always_comb begin
        w_lo_found = 1'b0;
        w_hi_found = 1'b0;
        w_lo_idx   = {W_SEL{1'b0}};
        w_hi_idx   = {W_SEL{1'b0}};
        for (int i = N_CHAN - 1; i >= 0; i--) begin
            w_lo_found = w_lo_found | r_pending[i];
            w_lo_idx   = r_pending[i] ? W_SEL'(i) : w_lo_idx;
            w_hi_found = w_hi_found | (r_pending[i] & (W_SEL'(i) >= r_ptr));
            w_hi_idx   = (r_pending[i] && (W_SEL'(i) >= r_ptr)) ? W_SEL'(i) : w_hi_idx;
        end
        w_grant_found = w_lo_found;
        if (w_hi_found) begin
            w_grant_idx = w_hi_idx;
        end else begin
            w_grant_idx = w_lo_idx;
        end
        w_grant_data = {W_CHAN{1'b0}};
        for (int i = 0; i < N_CHAN; i++) begin
            w_grant_data = (w_grant_idx == W_SEL'(i)) ? r_hold[i] : w_grant_data;
        end
        if (w_grant_idx == W_SEL'(N_CHAN - 1)) begin
            w_ptr_nxt = {W_SEL{1'b0}};
        end else begin
            w_ptr_nxt = w_grant_idx + W_SEL'(1);
        end
    end

    // Per-channel pending/overrun next state; a capture beats a same-edge grant.
    always_comb begin
        w_fire        = (r_state == ST_IDLE) && w_grant_found;
        w_capture     = data_valid_in & output_active_in;
        w_granted     = {N_CHAN{1'b0}};
        w_pending_nxt = r_pending;
        for (int i = 0; i < N_CHAN; i++) begin
            w_granted[i] = w_fire && (w_grant_idx == W_SEL'(i));
            if (!output_active_in[i]) begin
                w_pending_nxt[i] = 1'b0;
            end else if (w_capture[i]) begin
                w_pending_nxt[i] = 1'b1;
            end else if (w_granted[i]) begin
                w_pending_nxt[i] = 1'b0;
            end else begin
                w_pending_nxt[i] = r_pending[i];
            end
        end
        w_overrun_set = w_capture & r_pending & ~w_granted;
    end

    // Holding buffers, flags and the drain FSM.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            r_state   <= ST_IDLE;
            r_pending <= {N_CHAN{1'b0}};
            r_overrun <= {N_CHAN{1'b0}};
            r_ptr     <= {W_SEL{1'b0}};
            r_chan    <= {W_SEL{1'b0}};
            r_data    <= {W_CHAN{1'b0}};
            r_valid   <= 1'b0;
            for (int i = 0; i < N_CHAN; i++) begin
                r_hold[i] <= {W_CHAN{1'b0}};
            end
        end else begin
            r_pending <= w_pending_nxt;
            r_overrun <= (r_overrun & ~{N_CHAN{clear_overrun_in}}) | w_overrun_set;
            for (int i = 0; i < N_CHAN; i++) begin
                if (w_capture[i]) begin
                    r_hold[i] <= data_packed_in[i*W_CHAN +: W_CHAN];
                end else begin
                    r_hold[i] <= r_hold[i];
                end
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_fire) begin
                        r_data  <= w_grant_data;
                        r_chan  <= w_grant_idx;
                        r_valid <= 1'b1;
                        r_ptr   <= w_ptr_nxt;
                        r_state <= ST_SEND;
                    end else begin
                        r_valid <= 1'b0;
                    end
                end
                ST_SEND: begin
                    if (data_ready_in) begin
                        r_valid <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_valid <= 1'b1;
                    end
                end
                default: begin
                    r_valid <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign data_out       = r_data;
    assign chan_out       = r_chan;
    assign data_valid_out = r_valid;
    assign overrun_out    = r_overrun;

endmodule

// File: tb/tb_output_collector.sv
// Scoreboard bench for output_collector: stimulus pushes expected {chan,data},
// a negedge monitor pops and compares on each accepted handshake.
module tb_output_collector;

    logic         clk_in = 1'b0;
    logic         rst_n_in;
    logic [127:0] data_packed_in;
    logic [7:0]   data_valid_in;
    logic [7:0]   output_active_in;
    logic         clear_overrun_in;
    logic [15:0]  data_out;
    logic [3:0]   chan_out;
    logic         data_valid_out;
    logic         data_ready_in;
    logic [7:0]   overrun_out;

    int checks   = 0;
    int failures = 0;
    logic [19:0] exp_q[$];

    output_collector #(.W_CHAN(16), .W_SEL(4), .N_CHAN(8)) dut (
        .clk_in           (clk_in),
        .rst_n_in         (rst_n_in),
        .data_packed_in   (data_packed_in),
        .data_valid_in    (data_valid_in),
        .output_active_in (output_active_in),
        .clear_overrun_in (clear_overrun_in),
        .data_out         (data_out),
        .chan_out         (chan_out),
        .data_valid_out   (data_valid_out),
        .data_ready_in    (data_ready_in),
        .overrun_out      (overrun_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, expv);
        end
    endtask

    // Monitor: a handshake seen at negedge completes at the following posedge.
    always @(negedge clk_in) begin
        if (rst_n_in && data_valid_out && data_ready_in) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_word: got chan=%0d data=%h expected none", chan_out, data_out);
            end else begin
                logic [19:0] e;
                e = exp_q.pop_front();
                if ({chan_out, data_out} !== e) begin
                    failures++;
                    $display("FAIL sb_word: got chan=%0d data=%h expected chan=%0d data=%h",
                             chan_out, data_out, e[19:16], e[15:0]);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic set_word(input int ch, input logic [15:0] v);
        data_packed_in[ch*16 +: 16] = v;
    endtask

    task automatic pulse(input logic [7:0] mask);
        data_valid_in = mask;
        step();
        data_valid_in = 8'h00;
    endtask

    task automatic push(input int ch, input logic [15:0] v);
        exp_q.push_back({4'(ch), v});
    endtask

    task automatic drain(input string nm);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || data_valid_out) && n < 60) begin
            step();
            n++;
        end
        chk({nm, "_drain_timeout"}, 32'(n >= 60), 32'd0);
    endtask

    task automatic do_reset(input int cycles);
        rst_n_in = 1'b0;
        repeat (cycles) step();
        exp_q.delete();
        rst_n_in = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n_in = 1'b0;
        data_packed_in = 128'd0;
        data_valid_in = 8'h00;
        output_active_in = 8'hFF;
        clear_overrun_in = 1'b0;
        data_ready_in = 1'b1;

        // Reset and single word with latency
        do_reset(3);
        chk("reset_outputs", {11'd0, data_valid_out, chan_out, data_out}, 32'd0);
        chk("reset_overrun", 32'(overrun_out), 32'd0);
        set_word(3, 16'h1234);
        push(3, 16'h1234);
        pulse(8'h08);
        chk("lat_not_early", 32'(data_valid_out), 32'd0);
        step();
        chk("lat_valid", {11'd0, data_valid_out, chan_out, data_out}, {11'd0, 1'b1, 4'd3, 16'h1234});
        step();
        chk("valid_one_cycle", 32'(data_valid_out), 32'd0);
        drain("single");

        // Round-robin from ptr=0, then wrap
        do_reset(1);
        set_word(0, 16'h0A00); set_word(2, 16'h0A02); set_word(7, 16'h0A07);
        push(0, 16'h0A00); push(2, 16'h0A02); push(7, 16'h0A07);
        pulse(8'h85);
        drain("rr1");
        set_word(0, 16'h0B00); set_word(5, 16'h0B05);
        push(0, 16'h0B00); push(5, 16'h0B05);
        pulse(8'h21);
        drain("rr2");

        // Backpressure with a same-channel update during the stall
        data_ready_in = 1'b0;
        set_word(1, 16'hAAAA);
        push(1, 16'hAAAA);
        pulse(8'h02);
        step();
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                set_word(1, 16'hBBBB);
                push(1, 16'hBBBB);
                data_valid_in = 8'h02;
            end else begin
                data_valid_in = 8'h00;
            end
            step();
            chk("stall_stable", {11'd0, data_valid_out, chan_out, data_out}, {11'd0, 1'b1, 4'd1, 16'hAAAA});
        end
        data_valid_in = 8'h00;
        data_ready_in = 1'b1;
        drain("bp1");
        chk("no_overrun_bp", 32'(overrun_out), 32'd0);

        // Two updates to ch1 while ch3 is stalled -> overrun, only newest sent
        data_ready_in = 1'b0;
        set_word(3, 16'h3333);
        push(3, 16'h3333);
        pulse(8'h08);
        step();
        set_word(1, 16'hCCCC);
        pulse(8'h02);
        chk("overrun_first_upd", 32'(overrun_out), 32'd0);
        set_word(1, 16'hDDDD);
        pulse(8'h02);
        chk("overrun_set", 32'(overrun_out), 32'h02);
        push(1, 16'hDDDD);
        data_ready_in = 1'b1;
        drain("bp2");

        // Inactive channel ignored
        output_active_in = 8'hFB;
        set_word(2, 16'h2222);
        pulse(8'h04);
        repeat (3) step();
        chk("inactive_no_out", 32'(data_valid_out), 32'd0);
        chk("inactive_no_ovr", 32'(overrun_out), 32'h02);
        output_active_in = 8'hFF;

        // Pending ch4 dropped by deactivation before its grant
        data_ready_in = 1'b0;
        set_word(0, 16'h0F00);
        push(0, 16'h0F00);
        pulse(8'h01);
        step();
        set_word(4, 16'h4444);
        pulse(8'h10);
        output_active_in = 8'hEF;
        step();
        output_active_in = 8'hFF;
        data_ready_in = 1'b1;
        drain("deact");
        repeat (4) step();
        chk("deact_no_ch4", 32'(data_valid_out), 32'd0);

        // Clear race: clear old ch1 flag while a new ch6 overrun arrives
        data_ready_in = 1'b0;
        set_word(0, 16'h0C00);
        push(0, 16'h0C00);
        pulse(8'h01);
        step();
        set_word(6, 16'h6001);
        pulse(8'h40);
        set_word(6, 16'h6002);
        clear_overrun_in = 1'b1;
        pulse(8'h40);
        clear_overrun_in = 1'b0;
        chk("clear_race", 32'(overrun_out), 32'h40);
        push(6, 16'h6002);
        data_ready_in = 1'b1;
        drain("race");
        clear_overrun_in = 1'b1;
        step();
        clear_overrun_in = 1'b0;
        chk("clear_alone", 32'(overrun_out), 32'd0);

        // Reset during SEND drops the word, nothing stale afterwards
        data_ready_in = 1'b0;
        set_word(5, 16'h5555);
        push(5, 16'h5555);
        pulse(8'h20);
        step();
        chk("pre_rst_send", {11'd0, data_valid_out, chan_out, data_out}, {11'd0, 1'b1, 4'd5, 16'h5555});
        set_word(2, 16'h2020);
        pulse(8'h04);
        do_reset(1);
        chk("rst_send_outputs", {11'd0, data_valid_out, chan_out, data_out}, 32'd0);
        data_ready_in = 1'b1;
        repeat (5) step();
        chk("no_stale", 32'(data_valid_out), 32'd0);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
